// File: rtl/axis_pkg.sv
// Shared constants for the AXI-stream splitter.
// Split-mode encodings and the beat counter width.
package axis_pkg;

    localparam int SPLIT_HALVES    = 0;
    localparam int SPLIT_BROADCAST = 1;

    localparam int BEAT_CNT_W = 32;

    typedef logic [BEAT_CNT_W-1:0] beat_cnt_t;

endpackage

// File: rtl/axis_out_slot.sv
// One output slot of the splitter: data register, valid flag, handshake.
// A load always wins over a drain in the same cycle.
module axis_out_slot
    import axis_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic [W-1:0] tdata,
    output logic         tvalid,
    input  logic         tready,
    output logic         drain
);

    assign drain = tvalid & tready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            tvalid <= 1'b0;
            tdata  <= '0;
        end else if (load) begin
            tvalid <= 1'b1;
            tdata  <= load_data;
        end else if (drain) begin
            tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_stream_splitter.sv
// Forks one AXI-stream beat into two independently handshaken masters.
// AXIS_SPLITTER_FULLRATE_EN: allow refill while draining (1 beat/cycle).
module axis_stream_splitter
    import axis_pkg::*;
#(
    parameter int M00Size    = 16,
    parameter int M01Size    = 16,
    parameter int SSize      = M00Size + M01Size,
    parameter int SPLIT_MODE = SPLIT_HALVES
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [SSize-1:0]      s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [M00Size-1:0]    m00_axis_tdata,
    output logic                  m00_axis_tvalid,
    input  logic                  m00_axis_tready,
    output logic [M01Size-1:0]    m01_axis_tdata,
    output logic                  m01_axis_tvalid,
    input  logic                  m01_axis_tready,
    output logic [BEAT_CNT_W-1:0] beat_count
);

    logic [M00Size-1:0] m00_d;
    logic [M01Size-1:0] m01_d;
    logic               load;
    logic               drain00;
    logic               drain01;
    logic               retire;
    beat_cnt_t          beat_q;

    // Broadcast keeps LSBs when narrowing, sign-extends when widening.
    generate
        if (SPLIT_MODE == SPLIT_BROADCAST) begin : g_bcast
            if (SSize >= M00Size) begin : g_m00_trunc
                assign m00_d = s_axis_tdata[M00Size-1:0];
            end else begin : g_m00_ext
                assign m00_d = {{(M00Size-SSize){s_axis_tdata[SSize-1]}},
                                s_axis_tdata};
            end
            if (SSize >= M01Size) begin : g_m01_trunc
                assign m01_d = s_axis_tdata[M01Size-1:0];
            end else begin : g_m01_ext
                assign m01_d = {{(M01Size-SSize){s_axis_tdata[SSize-1]}},
                                s_axis_tdata};
            end
        end else begin : g_split
            assign m00_d = s_axis_tdata[SSize-1:M01Size];
            assign m01_d = s_axis_tdata[M01Size-1:0];
        end
    endgenerate

`ifdef AXIS_SPLITTER_FULLRATE_EN
    assign s_axis_tready = (~m00_axis_tvalid | m00_axis_tready)
                         & (~m01_axis_tvalid | m01_axis_tready);
`else
    assign s_axis_tready = ~m00_axis_tvalid & ~m01_axis_tvalid;
`endif

    assign load = s_axis_tvalid & s_axis_tready;

    axis_out_slot #(.W(M00Size)) u_m00 (
        .aclk      (aclk),
        .areset    (areset),
        .load      (load),
        .load_data (m00_d),
        .tdata     (m00_axis_tdata),
        .tvalid    (m00_axis_tvalid),
        .tready    (m00_axis_tready),
        .drain     (drain00)
    );

    axis_out_slot #(.W(M01Size)) u_m01 (
        .aclk      (aclk),
        .areset    (areset),
        .load      (load),
        .load_data (m01_d),
        .tdata     (m01_axis_tdata),
        .tvalid    (m01_axis_tvalid),
        .tready    (m01_axis_tready),
        .drain     (drain01)
    );

    // A beat retires when its last outstanding half leaves this cycle.
    assign retire = (m00_axis_tvalid | m01_axis_tvalid)
                  & (~m00_axis_tvalid | drain00)
                  & (~m01_axis_tvalid | drain01);

    always_ff @(posedge aclk) begin
        if (areset) begin
            beat_q <= '0;
        end else if (retire) begin
            beat_q <= beat_q + 1'b1;
        end
    end

    assign beat_count = beat_q;

endmodule

// File: tb/tb_axis_stream_splitter.sv
// Directed and randomized checks for axis_stream_splitter.
// Covers split, broadcast, backpressure, reset and throughput.
module tb_axis_stream_splitter;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [15:0] m00_tdata;
    logic        m00_tvalid;
    logic        m00_tready = 1'b1;
    logic [15:0] m01_tdata;
    logic        m01_tvalid;
    logic        m01_tready = 1'b1;
    logic [31:0] beat_count;

    logic [15:0] bc_s_tdata = '0;
    logic        bc_s_tvalid = 1'b0;
    logic        bc_s_tready;
    logic [23:0] bc_m00_tdata;
    logic        bc_m00_tvalid;
    logic [7:0]  bc_m01_tdata;
    logic        bc_m01_tvalid;
    logic [31:0] bc_beat_count;

    int checks = 0;
    int passed = 0;

    always #5 aclk = ~aclk;

    axis_stream_splitter u_dut (
        .aclk            (aclk),
        .areset          (areset),
        .s_axis_tdata    (s_tdata),
        .s_axis_tvalid   (s_tvalid),
        .s_axis_tready   (s_tready),
        .m00_axis_tdata  (m00_tdata),
        .m00_axis_tvalid (m00_tvalid),
        .m00_axis_tready (m00_tready),
        .m01_axis_tdata  (m01_tdata),
        .m01_axis_tvalid (m01_tvalid),
        .m01_axis_tready (m01_tready),
        .beat_count      (beat_count)
    );

    axis_stream_splitter #(
        .M00Size    (24),
        .M01Size    (8),
        .SSize      (16),
        .SPLIT_MODE (1)
    ) u_bc (
        .aclk            (aclk),
        .areset          (areset),
        .s_axis_tdata    (bc_s_tdata),
        .s_axis_tvalid   (bc_s_tvalid),
        .s_axis_tready   (bc_s_tready),
        .m00_axis_tdata  (bc_m00_tdata),
        .m00_axis_tvalid (bc_m00_tvalid),
        .m00_axis_tready (1'b1),
        .m01_axis_tdata  (bc_m01_tdata),
        .m01_axis_tvalid (bc_m01_tvalid),
        .m01_axis_tready (1'b1),
        .beat_count      (bc_beat_count)
    );

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset;
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if ({m00_tvalid, m01_tvalid, bc_m00_tvalid, bc_m01_tvalid} !== 4'b0)
            $display("FAIL rst_valid: got %b want 0000",
                     {m00_tvalid, m01_tvalid, bc_m00_tvalid, bc_m01_tvalid});
        else passed++;
        checks++;
        if ({m00_tdata, m01_tdata} !== 32'h0)
            $display("FAIL rst_data: got %h want 0", {m00_tdata, m01_tdata});
        else passed++;
        checks++;
        if (beat_count !== 32'd0)
            $display("FAIL rst_count: got %0d want 0", beat_count);
        else passed++;
        areset = 1'b0;
        @(negedge aclk);
        checks++;
        if (s_tready !== 1'b1)
            $display("FAIL rst_tready: got %b want 1", s_tready);
        else passed++;
    endtask

    task automatic test_split;
        tick();
        s_tvalid = 1'b1;
        s_tdata  = 32'h1234ABCD;
        tick();
        s_tvalid = 1'b0;
        checks++;
        if ({m00_tdata, m01_tdata} !== 32'h1234ABCD)
            $display("FAIL split_data: got %h want 1234abcd",
                     {m00_tdata, m01_tdata});
        else passed++;
        checks++;
        if ({m00_tvalid, m01_tvalid} !== 2'b11)
            $display("FAIL split_valid: got %b want 11",
                     {m00_tvalid, m01_tvalid});
        else passed++;
        checks++;
        if (beat_count !== 32'd0)
            $display("FAIL split_cnt0: got %0d want 0", beat_count);
        else passed++;
        tick();
        checks++;
        if (beat_count !== 32'd1)
            $display("FAIL split_cnt1: got %0d want 1", beat_count);
        else passed++;
        checks++;
        if ({m00_tvalid, m01_tvalid, s_tready} !== 3'b001)
            $display("FAIL split_idle: got %b want 001",
                     {m00_tvalid, m01_tvalid, s_tready});
        else passed++;
    endtask

    task automatic test_throughput;
        int acc = 0;
        int cyc = 0;
        int exp_cyc;
        bit took;
        bit done = 1'b0;
        logic [31:0] bc0;
`ifdef AXIS_SPLITTER_FULLRATE_EN
        exp_cyc = 10;
`else
        exp_cyc = 20;
`endif
        bc0 = beat_count;
        s_tvalid = 1'b1;
        s_tdata  = {16'h1000, 16'h2000};
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge aclk);
            took = s_tvalid && s_tready;
            if (took && acc == 10) begin
                s_tvalid = 1'b0;
                done = 1'b1;
            end else begin
                if (took) acc++;
                if (acc > 0) cyc++;
                @(posedge aclk);
                #1;
                if (took)
                    s_tdata = {16'h1000 + 16'(acc), 16'h2000 + 16'(acc)};
            end
        end
        s_tvalid = 1'b0;
        checks++;
        if (cyc !== exp_cyc || !done)
            $display("FAIL tput_cycles: got %0d want %0d", cyc, exp_cyc);
        else passed++;
        tick();
        tick();
        checks++;
        if (beat_count !== bc0 + 32'd10)
            $display("FAIL tput_count: got %0d want %0d",
                     beat_count, bc0 + 32'd10);
        else passed++;
    endtask

    task automatic test_backpressure;
        logic [31:0] bc0;
        int n00 = 0;
        int herr = 0;
        bc0 = beat_count;
        m00_tready = 1'b1;
        m01_tready = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 32'h1234ABCD;
        tick();
        s_tvalid = 1'b0;
        checks++;
        if ({m00_tvalid, m01_tvalid} !== 2'b11)
            $display("FAIL bp_valid: got %b want 11", {m00_tvalid, m01_tvalid});
        else passed++;
        repeat (5) begin
            @(negedge aclk);
            if (m00_tvalid && m00_tready) n00++;
            if (!m01_tvalid || m01_tdata !== 16'hABCD || s_tready
                || beat_count !== bc0) herr++;
        end
        checks++;
        if (n00 !== 1)
            $display("FAIL bp_m00_xfers: got %0d want 1", n00);
        else passed++;
        checks++;
        if (herr !== 0)
            $display("FAIL bp_hold: got %0d bad cycles want 0", herr);
        else passed++;
        m01_tready = 1'b1;
        tick();
        checks++;
        if (m01_tvalid !== 1'b0 || beat_count !== bc0 + 32'd1)
            $display("FAIL bp_release: got v=%b cnt=%0d want v=0 cnt=%0d",
                     m01_tvalid, beat_count, bc0 + 32'd1);
        else passed++;
        checks++;
        if (s_tready !== 1'b1)
            $display("FAIL bp_tready: got %b want 1", s_tready);
        else passed++;
    endtask

    task automatic test_broadcast;
        bc_s_tvalid = 1'b1;
        bc_s_tdata  = 16'h8001;
        tick();
        bc_s_tvalid = 1'b0;
        checks++;
        if (bc_m00_tdata !== 24'hFF8001 || bc_m01_tdata !== 8'h01)
            $display("FAIL bcast_neg: got %h/%h want ff8001/01",
                     bc_m00_tdata, bc_m01_tdata);
        else passed++;
        tick();
        bc_s_tvalid = 1'b1;
        bc_s_tdata  = 16'h7F80;
        tick();
        bc_s_tvalid = 1'b0;
        checks++;
        if (bc_m00_tdata !== 24'h007F80 || bc_m01_tdata !== 8'h80)
            $display("FAIL bcast_pos: got %h/%h want 007f80/80",
                     bc_m00_tdata, bc_m01_tdata);
        else passed++;
        tick();
        checks++;
        if (bc_beat_count !== 32'd2)
            $display("FAIL bcast_cnt: got %0d want 2", bc_beat_count);
        else passed++;
    endtask

    task automatic test_reset_mid;
        int stale = 0;
        m00_tready = 1'b1;
        m01_tready = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 32'hCAFEBEEF;
        tick();
        s_tvalid = 1'b0;
        tick();
        checks++;
        if ({m00_tvalid, m01_tvalid} !== 2'b01)
            $display("FAIL rmid_pre: got %b want 01", {m00_tvalid, m01_tvalid});
        else passed++;
        areset = 1'b1;
        tick();
        checks++;
        if (m01_tvalid !== 1'b0 || beat_count !== 32'd0 || m01_tdata !== 16'h0)
            $display("FAIL rmid_clear: got v=%b cnt=%0d d=%h want 0/0/0",
                     m01_tvalid, beat_count, m01_tdata);
        else passed++;
        areset = 1'b0;
        m01_tready = 1'b1;
        repeat (3) begin
            @(negedge aclk);
            if (m00_tvalid || m01_tvalid) stale++;
        end
        checks++;
        if (stale !== 0 || beat_count !== 32'd0)
            $display("FAIL rmid_stale: got %0d stale cnt=%0d want 0/0",
                     stale, beat_count);
        else passed++;
    endtask

    task automatic test_random;
        localparam int N = 10000;
        logic [15:0] q0[$];
        logic [15:0] q1[$];
        int sent = 0;
        int n0 = 0;
        int n1 = 0;
        int e0 = 0;
        int e1 = 0;
        int cyc = 0;
        bit took;
        areset = 1'b1;
        tick();
        areset = 1'b0;
        s_tvalid = 1'b0;
        while (cyc < 90000 && (sent < N || q0.size() > 0 || q1.size() > 0)) begin
            @(negedge aclk);
            if (m00_tvalid && m00_tready) begin
                if (q0.size() == 0 || m00_tdata !== q0[0]) e0++;
                if (q0.size() > 0) void'(q0.pop_front());
                n0++;
            end
            if (m01_tvalid && m01_tready) begin
                if (q1.size() == 0 || m01_tdata !== q1[0]) e1++;
                if (q1.size() > 0) void'(q1.pop_front());
                n1++;
            end
            took = s_tvalid && s_tready;
            if (took) begin
                q0.push_back(s_tdata[31:16]);
                q1.push_back(s_tdata[15:0]);
                sent++;
            end
            @(posedge aclk);
            #1;
            cyc++;
            if (took || !s_tvalid) begin
                s_tvalid = (sent < N) && ($urandom_range(3) != 0);
                s_tdata  = $urandom;
            end
            m00_tready = ($urandom_range(3) != 0);
            m01_tready = ($urandom_range(3) != 0);
        end
        s_tvalid = 1'b0;
        checks++;
        if (e0 !== 0 || n0 !== N)
            $display("FAIL rand_m00: got %0d errs %0d xfers want 0/%0d",
                     e0, n0, N);
        else passed++;
        checks++;
        if (e1 !== 0 || n1 !== N)
            $display("FAIL rand_m01: got %0d errs %0d xfers want 0/%0d",
                     e1, n1, N);
        else passed++;
        checks++;
        if (beat_count !== 32'(N))
            $display("FAIL rand_count: got %0d want %0d", beat_count, N);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_split();
        test_throughput();
        test_backpressure();
        test_broadcast();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
